// File: rtl/hazard_scoreboard_unit_if.sv
// ID-stage <-> hazard scoreboard unit signal bundle.
// Handshake: id_valid offers the ID instruction; it is accepted (issues) only in a cycle
// where id_valid=1 and the unit reports normal mode (pc_write=1, IF_ID_flush=0); otherwise ID holds or drops it.
interface hazard_scoreboard_unit_if #(
  parameter int REG_ADDR_W  = 5,
  parameter int LAT_W       = 3,
  parameter int STALL_CNT_W = 32
);
  logic                   id_valid;
  logic [REG_ADDR_W-1:0]  id_rs1;
  logic                   id_rs1_used;
  logic [REG_ADDR_W-1:0]  id_rs2;
  logic                   id_rs2_used;
  logic [REG_ADDR_W-1:0]  id_rd;
  logic                   id_rd_we;
  logic [LAT_W-1:0]       id_lat;
  logic                   flush_i;
  logic                   pipe_hold;
  logic                   pc_write;
  logic                   IF_ID_write;
  logic                   ctrl_sel;
  logic                   IF_ID_flush;
  logic [STALL_CNT_W-1:0] stall_cycles;
  // Decoded arbitration mode: 0 normal, 1 hazard stall, 2 flush, 3 hold.
  logic [1:0]             dbg_mode;

  modport master (
    output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
           id_rd, id_rd_we, id_lat, flush_i, pipe_hold,
    input  pc_write, IF_ID_write, ctrl_sel, IF_ID_flush, stall_cycles, dbg_mode
  );

  modport slave (
    input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
           id_rd, id_rd_we, id_lat, flush_i, pipe_hold,
    output pc_write, IF_ID_write, ctrl_sel, IF_ID_flush, stall_cycles, dbg_mode
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Per-register countdown scoreboard for variable-latency producers with hold/flush/stall arbitration.
// Optional macro HZD_WAW_CHECK_EN: also stall a younger write that would finish before an older pending write to the same rd.
module hazard_scoreboard_unit #(
  parameter int NUM_REGS    = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int MAX_LAT     = 7,
  parameter int LAT_W       = 3,
  parameter int STALL_CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  hazard_scoreboard_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_HAZ    = 2'd1,
    MODE_FLUSH  = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  localparam logic [LAT_W-1:0] MAX_LAT_C = LAT_W'(MAX_LAT);

  // x0 has no entry; lookups of index 0 fall through to zero.
  logic [LAT_W-1:0]       cnt_q [1:NUM_REGS-1];
  logic [STALL_CNT_W-1:0] stall_q;

  logic [LAT_W-1:0] rs1_cnt;
  logic [LAT_W-1:0] rs2_cnt;
  logic [LAT_W-1:0] lat_eff;
  logic             rs1_pend;
  logic             rs2_pend;
  logic             waw_pend;
  logic             haz;
  logic             alloc;
  mode_e            mode;

  always_comb begin
    rs1_cnt = '0;
    rs2_cnt = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (bus.id_rs1 == REG_ADDR_W'(r)) rs1_cnt = cnt_q[r];
      if (bus.id_rs2 == REG_ADDR_W'(r)) rs2_cnt = cnt_q[r];
    end
  end

  assign lat_eff  = (bus.id_lat > MAX_LAT_C) ? MAX_LAT_C : bus.id_lat;
  assign rs1_pend = bus.id_rs1_used && (bus.id_rs1 != '0) && (rs1_cnt != '0);
  assign rs2_pend = bus.id_rs2_used && (bus.id_rs2 != '0) && (rs2_cnt != '0);

`ifdef HZD_WAW_CHECK_EN
  logic [LAT_W-1:0] rd_cnt;

  always_comb begin
    rd_cnt = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (bus.id_rd == REG_ADDR_W'(r)) rd_cnt = cnt_q[r];
    end
  end

  assign waw_pend = bus.id_valid && bus.id_rd_we && (bus.id_rd != '0) && (rd_cnt > lat_eff);
`else
  assign waw_pend = 1'b0;
`endif

  assign haz = (bus.id_valid && (rs1_pend || rs2_pend)) || waw_pend;

  always_comb begin
    mode = MODE_NORMAL;
    if (bus.pipe_hold)    mode = MODE_HOLD;
    else if (bus.flush_i) mode = MODE_FLUSH;
    else if (haz)         mode = MODE_HAZ;
  end

  always_comb begin
    bus.pc_write    = 1'b1;
    bus.IF_ID_write = 1'b1;
    bus.ctrl_sel    = 1'b1;
    bus.IF_ID_flush = 1'b0;
    unique case (mode)
      MODE_HOLD: begin
        bus.pc_write    = 1'b0;
        bus.IF_ID_write = 1'b0;
      end
      MODE_FLUSH: begin
        bus.ctrl_sel    = 1'b0;
        bus.IF_ID_flush = 1'b1;
      end
      MODE_HAZ: begin
        bus.pc_write    = 1'b0;
        bus.IF_ID_write = 1'b0;
        bus.ctrl_sel    = 1'b0;
      end
      default: ;
    endcase
  end

  // Zero-latency producers never allocate; any older pending count keeps running down.
  assign alloc = (mode == MODE_NORMAL) && bus.id_valid && bus.id_rd_we &&
                 (bus.id_rd != '0) && (bus.id_lat != '0);

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q[r] <= '0;
      end else if (mode != MODE_HOLD) begin
        if (alloc && (bus.id_rd == REG_ADDR_W'(r))) begin
          cnt_q[r] <= lat_eff;
        end else if (cnt_q[r] != '0) begin
          cnt_q[r] <= cnt_q[r] - LAT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if ((mode == MODE_HAZ) && !(&stall_q)) begin
      stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.dbg_mode     = mode;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit: per-cycle scoreboard of controls and stall count,
// plus per-scenario bubble-count checks.
module tb_hazard_scoreboard_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [35:0] exp_q[$];
  int          m_cnt [32];
  int          m_stalls;

  hazard_scoreboard_unit_if bus ();

  hazard_scoreboard_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_stalls = 0;
  endtask

  // One cycle: drive at negedge, queue the expected response, compare, then advance the model.
  task automatic drive_cycle(input int v, input int rs1, input int u1, input int rs2, input int u2,
                             input int rd, input int we, input int lat, input int fl, input int hd);
    bit          p1, p2, haz;
    int          lat_c;
    logic [35:0] e;
    logic [35:0] got;
    @(negedge clk);
    bus.id_valid    = (v != 0);
    bus.id_rs1      = 5'(rs1);
    bus.id_rs1_used = (u1 != 0);
    bus.id_rs2      = 5'(rs2);
    bus.id_rs2_used = (u2 != 0);
    bus.id_rd       = 5'(rd);
    bus.id_rd_we    = (we != 0);
    bus.id_lat      = 3'(lat);
    bus.flush_i     = (fl != 0);
    bus.pipe_hold   = (hd != 0);
    lat_c = (lat > 7) ? 7 : lat;
    p1  = (u1 != 0) && (rs1 != 0) && (m_cnt[rs1] > 0);
    p2  = (u2 != 0) && (rs2 != 0) && (m_cnt[rs2] > 0);
    haz = (v != 0) && (p1 || p2);
`ifdef HZD_WAW_CHECK_EN
    if ((v != 0) && (we != 0) && (rd != 0) && (m_cnt[rd] > lat_c)) haz = 1'b1;
`endif
    if (hd != 0)      e = {4'b0010, 32'(m_stalls)};
    else if (fl != 0) e = {4'b1101, 32'(m_stalls)};
    else if (haz)     e = {4'b0000, 32'(m_stalls)};
    else              e = {4'b1110, 32'(m_stalls)};
    exp_q.push_back(e);
    #2;
    got = {bus.pc_write, bus.IF_ID_write, bus.ctrl_sel, bus.IF_ID_flush, bus.stall_cycles};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL sb_cycle t=%0t got=%h exp=%h", $time, got, e);
    end
    if (hd == 0) begin
      for (int i = 1; i < 32; i++) if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
      if (fl == 0 && haz && m_stalls != 32'hffff_ffff) m_stalls = m_stalls + 1;
      if (fl == 0 && !haz && v != 0 && we != 0 && rd != 0 && lat != 0) m_cnt[rd] = lat_c;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs1_used = 0; bus.id_rs2 = 0; bus.id_rs2_used = 0;
    bus.id_rd = 0; bus.id_rd_we = 0; bus.id_lat = 0; bus.flush_i = 0; bus.pipe_hold = 0;
    model_clear();
    #2;
    checks++;
    if ({bus.pc_write, bus.IF_ID_write, bus.ctrl_sel, bus.IF_ID_flush} !== 4'b1110) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=1110", {bus.pc_write, bus.IF_ID_write, bus.ctrl_sel, bus.IF_ID_flush});
    end
    checks++;
    if (bus.stall_cycles !== 32'd0) begin
      failures++;
      $display("FAIL reset_stalls got=%0d exp=0", bus.stall_cycles);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    drive_cycle(1, 1, 1, 2, 1, 3, 0, 0, 0, 0);
  endtask

  task automatic test_load_use();
    int bubbles = 0;
    bit issued  = 0;
    drive_cycle(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    for (int i = 0; i < 10 && !issued; i++) begin
      drive_cycle(1, 5, 1, 0, 0, 10, 1, 0, 0, 0);
      if (bus.pc_write === 1'b1) issued = 1; else bubbles++;
    end
    checks++;
    if (!issued || bubbles != 1) begin
      failures++;
      $display("FAIL load_use_bubbles got=%0d issued=%0d exp=1", bubbles, issued);
    end
    checks++;
    if (bus.stall_cycles !== 32'd1) begin
      failures++;
      $display("FAIL load_use_stalls got=%0d exp=1", bus.stall_cycles);
    end
  endtask

  task automatic test_div_latency();
    int bubbles = 0;
    bit issued  = 0;
    drive_cycle(1, 0, 0, 0, 0, 7, 1, 4, 0, 0);
    for (int i = 0; i < 12 && !issued; i++) begin
      drive_cycle(1, 1, 0, 7, 1, 11, 1, 0, 0, 0);
      if (bus.pc_write === 1'b1) issued = 1; else bubbles++;
    end
    checks++;
    if (!issued || bubbles != 4) begin
      failures++;
      $display("FAIL div_bubbles got=%0d issued=%0d exp=4", bubbles, issued);
    end
    checks++;
    if (bus.stall_cycles !== 32'd5) begin
      failures++;
      $display("FAIL div_stalls got=%0d exp=5", bus.stall_cycles);
    end
  endtask

  task automatic test_x0();
    drive_cycle(1, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    drive_cycle(1, 0, 1, 0, 1, 12, 1, 0, 0, 0);
    checks++;
    if (bus.pc_write !== 1'b1 || bus.ctrl_sel !== 1'b1 || bus.stall_cycles !== 32'd5) begin
      failures++;
      $display("FAIL x0_no_stall got pc=%b ctrl=%b stalls=%0d exp pc=1 ctrl=1 stalls=5",
               bus.pc_write, bus.ctrl_sel, bus.stall_cycles);
    end
  endtask

  task automatic test_flush();
    int bubbles = 0;
    bit issued  = 0;
    drive_cycle(1, 0, 0, 0, 0, 5, 1, 2, 0, 0);
    drive_cycle(1, 5, 1, 0, 0, 13, 1, 0, 1, 0);
    checks++;
    if ({bus.pc_write, bus.IF_ID_write, bus.ctrl_sel, bus.IF_ID_flush} !== 4'b1101 || bus.stall_cycles !== 32'd5) begin
      failures++;
      $display("FAIL flush_ctrl got=%b stalls=%0d exp=1101 stalls=5",
               {bus.pc_write, bus.IF_ID_write, bus.ctrl_sel, bus.IF_ID_flush}, bus.stall_cycles);
    end
    for (int i = 0; i < 10 && !issued; i++) begin
      drive_cycle(1, 5, 1, 0, 0, 13, 1, 0, 0, 0);
      if (bus.pc_write === 1'b1) issued = 1; else bubbles++;
    end
    checks++;
    if (!issued || bubbles != 1 || bus.stall_cycles !== 32'd6) begin
      failures++;
      $display("FAIL flush_decrement got bubbles=%0d stalls=%0d exp bubbles=1 stalls=6", bubbles, bus.stall_cycles);
    end
  endtask

  task automatic test_hold();
    int bubbles = 0;
    int held_ok = 0;
    bit issued  = 0;
    drive_cycle(1, 0, 0, 0, 0, 6, 1, 2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1, 6, 1, 0, 0, 14, 1, 0, 0, 1);
      if (bus.pc_write === 1'b0 && bus.ctrl_sel === 1'b1 && bus.IF_ID_flush === 1'b0) held_ok++;
    end
    checks++;
    if (held_ok != 3 || bus.stall_cycles !== 32'd6) begin
      failures++;
      $display("FAIL hold_ctrl got held=%0d stalls=%0d exp held=3 stalls=6", held_ok, bus.stall_cycles);
    end
    for (int i = 0; i < 10 && !issued; i++) begin
      drive_cycle(1, 6, 1, 0, 0, 14, 1, 0, 0, 0);
      if (bus.pc_write === 1'b1) issued = 1; else bubbles++;
    end
    checks++;
    if (!issued || bubbles != 2 || bus.stall_cycles !== 32'd8) begin
      failures++;
      $display("FAIL hold_release got bubbles=%0d stalls=%0d exp bubbles=2 stalls=8", bubbles, bus.stall_cycles);
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(1, 0, 0, 0, 0, 9, 1, 3, 0, 0);
    @(negedge clk);
    bus.id_valid = 1; bus.id_rs1 = 5'd9; bus.id_rs1_used = 1; bus.id_rs2 = 0; bus.id_rs2_used = 0;
    bus.id_rd = 5'd15; bus.id_rd_we = 0; bus.id_lat = 0; bus.flush_i = 0; bus.pipe_hold = 0;
    #1;
    checks++;
    if (bus.pc_write !== 1'b0) begin
      failures++;
      $display("FAIL pre_reset_stall got pc=%b exp pc=0", bus.pc_write);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.pc_write !== 1'b1 || bus.ctrl_sel !== 1'b1 || bus.stall_cycles !== 32'd0) begin
      failures++;
      $display("FAIL async_reset got pc=%b ctrl=%b stalls=%0d exp pc=1 ctrl=1 stalls=0",
               bus.pc_write, bus.ctrl_sel, bus.stall_cycles);
    end
    #1 rst_n = 1'b1;
    model_clear();
    drive_cycle(1, 9, 1, 9, 1, 15, 0, 0, 0, 0);
    checks++;
    if (bus.pc_write !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_issue got pc=%b exp pc=1", bus.pc_write);
    end
  endtask

  task automatic test_waw();
    int bubbles = 0;
    bit issued  = 0;
    drive_cycle(1, 0, 0, 0, 0, 3, 1, 4, 0, 0);
`ifdef HZD_WAW_CHECK_EN
    for (int i = 0; i < 10 && !issued; i++) begin
      drive_cycle(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
      if (bus.pc_write === 1'b1) issued = 1; else bubbles++;
    end
    checks++;
    if (!issued || bubbles != 3 || bus.stall_cycles !== 32'd3) begin
      failures++;
      $display("FAIL waw_stall got bubbles=%0d stalls=%0d exp bubbles=3 stalls=3", bubbles, bus.stall_cycles);
    end
`else
    drive_cycle(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    checks++;
    if (bus.pc_write !== 1'b1) begin
      failures++;
      $display("FAIL waw_overwrite got pc=%b exp pc=1", bus.pc_write);
    end
    for (int i = 0; i < 10 && !issued; i++) begin
      drive_cycle(1, 3, 1, 0, 0, 16, 0, 0, 0, 0);
      if (bus.pc_write === 1'b1) issued = 1; else bubbles++;
    end
    checks++;
    if (!issued || bubbles != 1 || bus.stall_cycles !== 32'd1) begin
      failures++;
      $display("FAIL waw_shortened got bubbles=%0d stalls=%0d exp bubbles=1 stalls=1", bubbles, bus.stall_cycles);
    end
`endif
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      drive_cycle(($urandom_range(0, 9) != 0) ? 1 : 0,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)),
                  ($urandom_range(0, 15) == 0) ? 1 : 0,
                  ($urandom_range(0, 15) == 0) ? 1 : 0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_load_use();
    test_div_latency();
    test_x0();
    test_flush();
    test_hold();
    test_async_reset();
    test_waw();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
